// File: rtl/sha_job_loader_if.sv
// Byte-stream and job handshake bundle between the UART receiver, the job loader
// and the hash core.
interface sha_job_loader_if;
    logic         abort;
    logic         in_valid;
    logic [7:0]   in_data;
    logic         in_ready;
    logic         job_valid;
    logic         job_ready;
    logic [95:0]  job_data;
    logic [255:0] job_state;
    logic [255:0] job_target;
    logic [31:0]  job_nonce_base;
    logic [31:0]  job_position;
    logic         timeout_err;
    logic [6:0]   byte_cnt;

    modport master (
        output abort, in_valid, in_data, job_ready,
        input  in_ready, job_valid, job_data, job_state, job_target,
               job_nonce_base, job_position, timeout_err, byte_cnt
    );

    modport slave (
        input  abort, in_valid, in_data, job_ready,
        output in_ready, job_valid, job_data, job_state, job_target,
               job_nonce_base, job_position, timeout_err, byte_cnt
    );
endinterface

// File: rtl/sha_job_loader.sv
// Assembles an 84-byte mining job from a UART byte stream and holds it for the
// hash core until handshake; partial jobs are dropped on idle timeout or abort.
module sha_job_loader #(
    parameter int unsigned TIMEOUT_CYCLES = 10_000_000
) (
    input logic             clk,
    input logic             rst,
    sha_job_loader_if.slave bus
);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_HOLD} state_e;
    typedef enum logic [2:0] {F_DATA, F_STATE, F_TARGET, F_NONCE, F_POS} field_e;

    state_e         state_q;
    field_e         field_q;
    logic [4:0]     k_q;
    logic [6:0]     byte_cnt_q, byte_cnt_d;
    logic [TW-1:0]  tmo_q, tmo_d;
    logic           job_valid_q;
    logic           timeout_err_q;
    logic [95:0]    job_data_q;
    logic [255:0]   job_state_q;
    logic [255:0]   job_target_q;
    logic [31:0]    job_nonce_base_q;
    logic [31:0]    job_position_q;
    logic           accept;

    function automatic logic [4:0] field_last(input field_e f);
        case (f)
            F_DATA:   return 5'd11;
            F_STATE:  return 5'd31;
            F_TARGET: return 5'd31;
            default:  return 5'd3;
        endcase
    endfunction

    function automatic field_e field_next(input field_e f);
        case (f)
            F_DATA:   return F_STATE;
            F_STATE:  return F_TARGET;
            F_TARGET: return F_NONCE;
            F_NONCE:  return F_POS;
            default:  return F_DATA;
        endcase
    endfunction

    // NOTE: in_ready depends only on state, abort and rst so the receiver can never
    // form a combinational loop through in_valid.
    assign bus.in_ready = !rst && !bus.abort && (state_q != S_HOLD);
    assign accept       = bus.in_valid && bus.in_ready;
    assign byte_cnt_d   = byte_cnt_q + 7'd1;
    assign tmo_d        = tmo_q + TW'(1);

    // NOTE: the job registers are ordinary flops, not a RAM, so they take the
    // synchronous reset and read back as zero after rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= S_IDLE;
            field_q          <= F_DATA;
            k_q              <= '0;
            byte_cnt_q       <= '0;
            tmo_q            <= '0;
            job_valid_q      <= 1'b0;
            timeout_err_q    <= 1'b0;
            job_data_q       <= '0;
            job_state_q      <= '0;
            job_target_q     <= '0;
            job_nonce_base_q <= '0;
            job_position_q   <= '0;
        end else if (bus.abort) begin
            state_q       <= S_IDLE;
            field_q       <= F_DATA;
            k_q           <= '0;
            byte_cnt_q    <= '0;
            tmo_q         <= '0;
            job_valid_q   <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            timeout_err_q <= 1'b0;
            case (state_q)
                S_IDLE, S_LOAD: begin
                    if (accept) begin
                        case (field_q)
                            F_DATA:   job_data_q[{k_q[3:0], 3'b000} +: 8]       <= bus.in_data;
                            F_STATE:  job_state_q[{k_q, 3'b000} +: 8]           <= bus.in_data;
                            F_TARGET: job_target_q[{k_q, 3'b000} +: 8]          <= bus.in_data;
                            F_NONCE:  job_nonce_base_q[{k_q[1:0], 3'b000} +: 8] <= bus.in_data;
                            default:  job_position_q[{k_q[1:0], 3'b000} +: 8]   <= bus.in_data;
                        endcase
                        if (k_q == field_last(field_q)) begin
                            k_q     <= '0;
                            field_q <= field_next(field_q);
                        end else begin
                            k_q <= k_q + 5'd1;
                        end
                        byte_cnt_q <= byte_cnt_d;
                        tmo_q      <= '0;
                        if (byte_cnt_q == 7'd83) begin
                            state_q     <= S_HOLD;
                            job_valid_q <= 1'b1;
                        end else begin
                            state_q <= S_LOAD;
                        end
                    end else if (state_q == S_LOAD) begin
                        // An accepted byte above takes priority over expiry.
                        if (tmo_q == TMO_LAST) begin
                            state_q       <= S_IDLE;
                            field_q       <= F_DATA;
                            k_q           <= '0;
                            byte_cnt_q    <= '0;
                            tmo_q         <= '0;
                            timeout_err_q <= 1'b1;
                        end else begin
                            tmo_q <= tmo_d;
                        end
                    end
                end
                S_HOLD: begin
                    if (bus.job_ready) begin
                        state_q     <= S_IDLE;
                        field_q     <= F_DATA;
                        k_q         <= '0;
                        byte_cnt_q  <= '0;
                        tmo_q       <= '0;
                        job_valid_q <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.job_valid      = job_valid_q;
    assign bus.timeout_err    = timeout_err_q;
    assign bus.byte_cnt       = byte_cnt_q;
    assign bus.job_data       = job_data_q;
    assign bus.job_state      = job_state_q;
    assign bus.job_target     = job_target_q;
    assign bus.job_nonce_base = job_nonce_base_q;
    assign bus.job_position   = job_position_q;
endmodule

// File: tb/tb_sha_job_loader.sv
// Directed bench for sha_job_loader with a 16-cycle timeout; expected job fields
// come from an independent byte-to-field placement model.
module tb_sha_job_loader;
    logic clk;
    logic rst;
    int   checks;
    int   passed;

    sha_job_loader_if bus ();

    sha_job_loader #(.TIMEOUT_CYCLES(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [671:0] exp_job(input logic [7:0] base);
        logic [95:0]  d;
        logic [255:0] s;
        logic [255:0] t;
        logic [31:0]  n;
        logic [31:0]  p;
        for (int i = 0; i < 12; i++) d[8*i +: 8] = base + 8'(i);
        for (int i = 0; i < 32; i++) begin
            s[8*i +: 8] = base + 8'(12 + i);
            t[8*i +: 8] = base + 8'(44 + i);
        end
        for (int i = 0; i < 4; i++) begin
            n[8*i +: 8] = base + 8'(76 + i);
            p[8*i +: 8] = base + 8'(80 + i);
        end
        return {d, s, t, n, p};
    endfunction

    function automatic logic [671:0] got_job();
        return {bus.job_data, bus.job_state, bus.job_target, bus.job_nonce_base, bus.job_position};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers n consecutive bytes base, base+1, ... with gap idle cycles between them.
    task automatic send_bytes(input logic [7:0] base, input int n, input int gap, output int tmo_seen);
        tmo_seen = 0;
        for (int i = 0; i < n; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = base + 8'(i);
            tick();
            if (bus.timeout_err) tmo_seen++;
            bus.in_valid = 1'b0;
            if (i < n - 1) begin
                repeat (gap) begin
                    tick();
                    if (bus.timeout_err) tmo_seen++;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b expected 0", bus.in_ready); else passed++;
        tick();
        tick();
        checks++; if (bus.byte_cnt !== 7'd0) $display("FAIL reset_byte_cnt: got %0d expected 0", bus.byte_cnt); else passed++;
        checks++; if (bus.job_valid !== 1'b0 || bus.timeout_err !== 1'b0) $display("FAIL reset_flags: got valid=%b err=%b expected 0/0", bus.job_valid, bus.timeout_err); else passed++;
        checks++; if (got_job() !== '0) $display("FAIL reset_fields: got %h expected 0", got_job()); else passed++;
        rst = 1'b0;
        #1;
        checks++; if (bus.in_ready !== 1'b1) $display("FAIL idle_in_ready: got %b expected 1", bus.in_ready); else passed++;
    endtask

    task automatic test_back_to_back();
        int ts;
        bus.job_ready = 1'b1;
        send_bytes(8'h00, 83, 0, ts);
        checks++; if (bus.byte_cnt !== 7'd83 || bus.job_valid !== 1'b0) $display("FAIL b2b_before_last: got cnt=%0d valid=%b expected 83/0", bus.byte_cnt, bus.job_valid); else passed++;
        send_bytes(8'h53, 1, 0, ts);
        checks++; if (bus.job_valid !== 1'b1 || bus.byte_cnt !== 7'd84) $display("FAIL b2b_valid: got valid=%b cnt=%0d expected 1/84", bus.job_valid, bus.byte_cnt); else passed++;
        checks++; if (bus.in_ready !== 1'b0) $display("FAIL b2b_hold_ready: got %b expected 0", bus.in_ready); else passed++;
        checks++; if (bus.job_data[7:0] !== 8'h00 || bus.job_state[7:0] !== 8'h0C || bus.job_target[255:248] !== 8'h4B)
            $display("FAIL b2b_bytes: got data0=%h state0=%h target31=%h expected 00/0c/4b", bus.job_data[7:0], bus.job_state[7:0], bus.job_target[255:248]); else passed++;
        checks++; if (bus.job_nonce_base !== 32'h4F4E4D4C || bus.job_position !== 32'h53525150)
            $display("FAIL b2b_nonce_pos: got %h/%h expected 4f4e4d4c/53525150", bus.job_nonce_base, bus.job_position); else passed++;
        checks++; if (got_job() !== exp_job(8'h00)) $display("FAIL b2b_fields: got %h expected %h", got_job(), exp_job(8'h00)); else passed++;
        tick();
        checks++; if (bus.job_valid !== 1'b0 || bus.byte_cnt !== 7'd0 || bus.in_ready !== 1'b1)
            $display("FAIL b2b_release: got valid=%b cnt=%0d ready=%b expected 0/0/1", bus.job_valid, bus.byte_cnt, bus.in_ready); else passed++;
        checks++; if (got_job() !== exp_job(8'h00)) $display("FAIL b2b_retain: got %h expected %h", got_job(), exp_job(8'h00)); else passed++;
        bus.job_ready = 1'b0;
    endtask

    task automatic test_hold();
        int ts;
        int errs;
        errs = 0;
        send_bytes(8'h80, 84, 0, ts);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hFF;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (bus.job_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.byte_cnt !== 7'd84) errs++;
        end
        checks++; if (errs !== 0) $display("FAIL hold_stable: got %0d bad cycles expected 0", errs); else passed++;
        checks++; if (got_job() !== exp_job(8'h80)) $display("FAIL hold_fields: got %h expected %h", got_job(), exp_job(8'h80)); else passed++;
        bus.in_valid  = 1'b0;
        bus.job_ready = 1'b1;
        tick();
        bus.job_ready = 1'b0;
        checks++; if (bus.job_valid !== 1'b0 || bus.byte_cnt !== 7'd0 || bus.in_ready !== 1'b1)
            $display("FAIL hold_release: got valid=%b cnt=%0d ready=%b expected 0/0/1", bus.job_valid, bus.byte_cnt, bus.in_ready); else passed++;
    endtask

    task automatic test_timeout();
        int ts;
        int first;
        int pulses;
        first = 0;
        send_bytes(8'h10, 10, 0, ts);
        for (int c = 1; c <= 40 && first == 0; c++) begin
            tick();
            if (bus.timeout_err === 1'b1) first = c;
        end
        checks++; if (first !== 16) $display("FAIL timeout_cycle: got %0d expected 16", first); else passed++;
        checks++; if (bus.byte_cnt !== 7'd0) $display("FAIL timeout_byte_cnt: got %0d expected 0", bus.byte_cnt); else passed++;
        pulses = 0;
        repeat (25) begin
            tick();
            if (bus.timeout_err !== 1'b0) pulses++;
        end
        checks++; if (pulses !== 0) $display("FAIL timeout_single_pulse: got %0d extra expected 0", pulses); else passed++;
        send_bytes(8'h20, 84, 0, ts);
        checks++; if (bus.job_valid !== 1'b1 || got_job() !== exp_job(8'h20)) $display("FAIL timeout_next_job: got %h expected %h", got_job(), exp_job(8'h20)); else passed++;
        pulses = 0;
        repeat (25) begin
            tick();
            if (bus.timeout_err !== 1'b0 || bus.job_valid !== 1'b1) pulses++;
        end
        checks++; if (pulses !== 0) $display("FAIL timeout_in_hold: got %0d bad cycles expected 0", pulses); else passed++;
        bus.job_ready = 1'b1;
        tick();
        bus.job_ready = 1'b0;
    endtask

    task automatic test_gaps();
        int ts;
        send_bytes(8'h30, 84, 15, ts);
        checks++; if (ts !== 0) $display("FAIL gaps_no_timeout: got %0d pulses expected 0", ts); else passed++;
        checks++; if (bus.job_valid !== 1'b1 || got_job() !== exp_job(8'h30)) $display("FAIL gaps_job: got %h expected %h", got_job(), exp_job(8'h30)); else passed++;
        bus.job_ready = 1'b1;
        tick();
        bus.job_ready = 1'b0;
    endtask

    task automatic test_abort();
        int ts;
        bus.job_ready = 1'b1;
        send_bytes(8'h00, 5, 0, ts);
        checks++; if (bus.byte_cnt !== 7'd5 || bus.job_valid !== 1'b0) $display("FAIL ready_ignored: got cnt=%0d valid=%b expected 5/0", bus.byte_cnt, bus.job_valid); else passed++;
        bus.job_ready = 1'b0;
        send_bytes(8'h05, 35, 0, ts);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h28;
        bus.abort    = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b0) $display("FAIL abort_in_ready: got %b expected 0", bus.in_ready); else passed++;
        tick();
        bus.abort    = 1'b0;
        bus.in_valid = 1'b0;
        checks++; if (bus.byte_cnt !== 7'd0 || bus.job_valid !== 1'b0) $display("FAIL abort_load: got cnt=%0d valid=%b expected 0/0", bus.byte_cnt, bus.job_valid); else passed++;
        send_bytes(8'h40, 84, 0, ts);
        checks++; if (bus.job_valid !== 1'b1 || got_job() !== exp_job(8'h40)) $display("FAIL abort_restart_job: got %h expected %h", got_job(), exp_job(8'h40)); else passed++;
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        checks++; if (bus.job_valid !== 1'b0 || bus.byte_cnt !== 7'd0 || bus.timeout_err !== 1'b0)
            $display("FAIL abort_hold: got valid=%b cnt=%0d err=%b expected 0/0/0", bus.job_valid, bus.byte_cnt, bus.timeout_err); else passed++;
    endtask

    task automatic test_rst_mid();
        int ts;
        send_bytes(8'h50, 50, 0, ts);
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b0) $display("FAIL rst_load_in_ready: got %b expected 0", bus.in_ready); else passed++;
        tick();
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        checks++; if (bus.byte_cnt !== 7'd0 || bus.job_valid !== 1'b0 || bus.timeout_err !== 1'b0 || got_job() !== '0)
            $display("FAIL rst_load: got cnt=%0d valid=%b fields=%h expected all 0", bus.byte_cnt, bus.job_valid, got_job()); else passed++;
        send_bytes(8'h60, 84, 0, ts);
        checks++; if (bus.job_valid !== 1'b1 || got_job() !== exp_job(8'h60)) $display("FAIL rst_hold_job: got %h expected %h", got_job(), exp_job(8'h60)); else passed++;
        rst           = 1'b1;
        bus.job_ready = 1'b1;
        tick();
        rst           = 1'b0;
        bus.job_ready = 1'b0;
        #1;
        checks++; if (bus.byte_cnt !== 7'd0 || bus.job_valid !== 1'b0 || got_job() !== '0 || bus.in_ready !== 1'b1)
            $display("FAIL rst_hold: got cnt=%0d valid=%b ready=%b fields=%h expected 0/0/1/0", bus.byte_cnt, bus.job_valid, bus.in_ready, got_job()); else passed++;
    endtask

    initial begin
        checks        = 0;
        passed        = 0;
        rst           = 1'b1;
        bus.abort     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.job_ready = 1'b0;
        test_reset();
        test_back_to_back();
        test_hold();
        test_timeout();
        test_gaps();
        test_abort();
        test_rst_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/sha_job_loader.md
SHA_JOB_LOADER -- requirements
Module: sha_job_loader

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 10_000_000, max idle cycles between bytes of a partial job before discard.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 abort  input  1  discard partial or held job, return to IDLE.
REQ-005 in_valid  input  1  byte from UART receiver valid.
REQ-006 in_data  input  8  received byte.
REQ-007 in_ready  output  1  loader accepts byte this cycle.
REQ-008 job_valid  output  1  complete job held on job_* outputs.
REQ-009 job_ready  input  1  hash core consumes job.
REQ-010 job_data  output  96  header tail, 12 bytes.
REQ-011 job_state  output  256  SHA-256 midstate, 32 bytes.
REQ-012 job_target  output  256  difficulty target, 32 bytes.
REQ-013 job_nonce_base  output  32  starting nonce.
REQ-014 job_position  output  32  nonce byte position.
REQ-015 timeout_err  output  1  one-cycle pulse when a partial job is discarded on timeout.
REQ-016 byte_cnt  output  7  bytes accepted in current job, 0..84.

Function
REQ-017 States: IDLE (byte_cnt=0, waiting), LOAD (0<byte_cnt<84), HOLD (84 bytes, job_valid=1).
REQ-018 Byte accepted on cycle where in_valid && in_ready; byte_cnt increments by 1 on that cycle.
REQ-019 in_ready = 1 in IDLE and LOAD, 0 in HOLD; combinational from state only, never from in_valid.
REQ-020 Stream order: bytes 0-11 job_data, 12-43 job_state, 44-75 job_target, 76-79 job_nonce_base, 80-83 job_position.
REQ-021 Within each field, field byte k (k counted from field's first stream byte) lands in bits [8k+7:8k].
REQ-022 Each accepted byte written to its field register in the accept cycle; other bits of that field unchanged.
REQ-023 IDLE -> LOAD on first accepted byte.
REQ-024 Accept of byte 83 -> HOLD; job_valid=1 from next cycle; latency last byte to job_valid = 1 cycle.
REQ-025 In HOLD all job_* outputs stable until handshake job_valid && job_ready.
REQ-026 Handshake cycle -> IDLE next cycle: job_valid=0, byte_cnt=0, in_ready=1; job_* fields retain last values.
REQ-027 job_ready while job_valid=0 ignored.
REQ-028 Timeout counter: cleared on each accepted byte and on entry to IDLE; counts only in LOAD.
REQ-029 Counter reaching TIMEOUT_CYCLES in LOAD -> IDLE, byte_cnt=0, timeout_err=1 for exactly one cycle; no timeout in IDLE or HOLD.
REQ-030 Byte accepted on same cycle counter would expire: byte wins, counter cleared, no timeout_err.
REQ-031 abort=1: next cycle IDLE, byte_cnt=0, job_valid=0, timeout_err=0; byte offered same cycle not accepted (in_ready forced 0 when abort=1); overrides handshake and timeout.
REQ-032 Timeout counter width ceil(log2(TIMEOUT_CYCLES+1)); byte_cnt never exceeds 84, never wraps.

Reset
REQ-033 rst=1 on rising edge: state IDLE, byte_cnt=0, job_valid=0, timeout_err=0, timeout counter=0, all job_* fields 0.
REQ-034 in_ready=0 while rst=1; rst overrides abort, handshake, byte accept; reset mid-LOAD or mid-HOLD discards job.

Verification
REQ-035 Send bytes 0x00..0x53 back-to-back, job_ready=1 -> job_valid one cycle after byte 83 for one cycle; job_data[7:0]=0x00, job_state[7:0]=0x0C, job_target[255:248]=0x4B, job_nonce_base=0x4F4E4D4C, job_position=0x53525150.
REQ-036 Full job, job_ready=0 for 20 cycles -> job_valid held, in_ready=0, extra in_valid bytes not accepted, fields unchanged; job_ready=1 -> IDLE next cycle.
REQ-037 TIMEOUT_CYCLES=16, send 10 bytes then stop -> timeout_err pulse once, byte_cnt=0; next 84 bytes form a correct job.
REQ-038 TIMEOUT_CYCLES=16, gaps of 15 idle cycles between bytes -> no timeout_err, job completes.
REQ-039 abort asserted at byte 40 -> byte_cnt=0 next cycle, no job_valid; abort in HOLD -> job_valid=0 next cycle.
REQ-040 rst pulsed during LOAD (byte 50) and during HOLD -> all outputs per REQ-033 next cycle.
